// File: rtl/branch_resolve_pkg.sv
// Shared types and widths for the branch resolve unit.
// Condition codes, FSM states and status-register bit positions.
package branch_resolve_pkg;

  localparam int COND_CODE_WIDTH = 4;
  localparam int IM_ADDR_WIDTH   = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [COND_CODE_WIDTH-1:0] {
    CC_AL = 4'd0,
    CC_EQ = 4'd1,
    CC_NE = 4'd2,
    CC_CS = 4'd3,
    CC_CC = 4'd4,
    CC_MI = 4'd5,
    CC_PL = 4'd6,
    CC_VS = 4'd7,
    CC_VC = 4'd8,
    CC_HI = 4'd9,
    CC_LS = 4'd10,
    CC_GE = 4'd11,
    CC_LT = 4'd12,
    CC_GT = 4'd13,
    CC_LE = 4'd14,
    CC_NV = 4'd15
  } cond_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational branch condition evaluator.
// Tests a condition code against the {N,Z,C,V} status register.
module cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [COND_CODE_WIDTH-1:0] condcode,
  input  logic [3:0]                 sr,
  output logic                       cond_true
);

  logic n, z, c, v;

  assign n = sr[FLAG_N];
  assign z = sr[FLAG_Z];
  assign c = sr[FLAG_C];
  assign v = sr[FLAG_V];

  // Decode the condition code into a single truth value.
  always_comb begin
    cond_true = 1'b0;
    case (condcode)
      CC_AL:   cond_true = 1'b1;
      CC_EQ:   cond_true = z;
      CC_NE:   cond_true = !z;
      CC_CS:   cond_true = c;
      CC_CC:   cond_true = !c;
      CC_MI:   cond_true = n;
      CC_PL:   cond_true = !n;
      CC_VS:   cond_true = v;
      CC_VC:   cond_true = !v;
      CC_HI:   cond_true = c & !z;
      CC_LS:   cond_true = !c | z;
      CC_GE:   cond_true = (n == v);
      CC_LT:   cond_true = (n != v);
      CC_GT:   cond_true = !z & (n == v);
      CC_LE:   cond_true = z | (n != v);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: SR update, condition check, fetch redirect.
// A taken branch squashes younger instructions for FLUSH_CYCLES.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branchen_i,
  input  logic [COND_CODE_WIDTH-1:0] condcode_i,
  input  logic [IM_ADDR_WIDTH-1:0]   branchtrgt_i,
  input  logic                       sr_we_i,
  input  logic [3:0]                 flags_i,
  output logic                       br_taken_o,
  output logic [IM_ADDR_WIDTH-1:0]   br_target_o,
  output logic                       flush_o,
  output logic [3:0]                 sr_o,
  output logic [15:0]                taken_cnt_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e                     state_q;
  state_e                     state_d;
  logic [3:0]                 cnt_q;
  logic [3:0]                 sr_q;
  logic                       cond_true;
  logic                       accept;
  logic                       take;
  logic                       flush_done;
  logic                       br_taken_q;
  logic [IM_ADDR_WIDTH-1:0]   target_q;
  logic                       flush_q;
  logic [15:0]                taken_cnt_q;

  // Condition is checked against the registered SR, so a same-cycle
  // SR write never affects the branch it travels with.
  cond_eval u_cond_eval (
    .condcode  (condcode_i),
    .sr        (sr_q),
    .cond_true (cond_true)
  );

  assign accept     = (state_q == ST_IDLE);
  assign take       = accept & branchen_i & cond_true;
  assign flush_done = (state_q == ST_FLUSH) && (cnt_q == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (take)       state_d = ST_FLUSH;
      ST_FLUSH: if (flush_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush length down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt_q <= 4'd0;
    else if (take)                cnt_q <= FLUSH_LOAD;
    else if (state_q == ST_FLUSH) cnt_q <= cnt_q - 4'd1;
  end

  // Registered flush tracks the FLUSH state one-for-one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_q <= 1'b0;
    else      flush_q <= (state_d == ST_FLUSH);
  end

  // Redirect pulse and held target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_taken_q <= 1'b0;
      target_q   <= '0;
    end else begin
      br_taken_q <= take;
      if (take) target_q <= branchtrgt_i;
    end
  end

  // Status register update for accepted writers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   sr_q <= 4'b0000;
    else if (accept && sr_we_i) sr_q <= flags_i;
  end

  // Saturating taken-branch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      taken_cnt_q <= 16'd0;
    else if (take && taken_cnt_q != 16'hFFFF)
      taken_cnt_q <= taken_cnt_q + 16'd1;
  end

  assign br_taken_o  = br_taken_q;
  assign br_target_o = target_q;
  assign flush_o     = flush_q;
  assign sr_o        = sr_q;
  assign taken_cnt_o = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
// One task per scenario, expected values computed by hand.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        branchen_i;
  logic [3:0]  condcode_i;
  logic [15:0] branchtrgt_i;
  logic        sr_we_i;
  logic [3:0]  flags_i;
  logic        br_taken_o;
  logic [15:0] br_target_o;
  logic        flush_o;
  logic [3:0]  sr_o;
  logic [15:0] taken_cnt_o;

  int errors = 0;
  int checks = 0;

  branch_resolve #(.FLUSH_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .branchen_i   (branchen_i),
    .condcode_i   (condcode_i),
    .branchtrgt_i (branchtrgt_i),
    .sr_we_i      (sr_we_i),
    .flags_i      (flags_i),
    .br_taken_o   (br_taken_o),
    .br_target_o  (br_target_o),
    .flush_o      (flush_o),
    .sr_o         (sr_o),
    .taken_cnt_o  (taken_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    branchen_i   = 1'b0;
    condcode_i   = 4'd0;
    branchtrgt_i = 16'h0000;
    sr_we_i      = 1'b0;
    flags_i      = 4'b0000;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic model(input logic [3:0] cc, input logic [3:0] s);
    logic n, z, c, v;
    n = s[3]; z = s[2]; c = s[1]; v = s[0];
    case (cc)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return c;
      4'd4:    return !c;
      4'd5:    return n;
      4'd6:    return !n;
      4'd7:    return v;
      4'd8:    return !v;
      4'd9:    return c && !z;
      4'd10:   return !c || z;
      4'd11:   return n == v;
      4'd12:   return n != v;
      4'd13:   return !z && (n == v);
      4'd14:   return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (br_taken_o !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %b want 0", br_taken_o);
    end
    checks++;
    if (br_target_o !== 16'h0000) begin
      errors++; $display("FAIL reset_target: got %h want 0000", br_target_o);
    end
    checks++;
    if (flush_o !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got %b want 0", flush_o);
    end
    checks++;
    if (sr_o !== 4'b0000) begin
      errors++; $display("FAIL reset_sr: got %b want 0000", sr_o);
    end
    checks++;
    if (taken_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_taken();
    int n;
    do_reset();
    sr_we_i = 1'b1;
    flags_i = 4'b0100;
    step();
    checks++;
    if (sr_o !== 4'b0100) begin
      errors++; $display("FAIL taken_sr: got %b want 0100", sr_o);
    end
    idle_in();
    branchen_i   = 1'b1;
    condcode_i   = 4'd1;
    branchtrgt_i = 16'h0040;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b1) begin
      errors++; $display("FAIL taken_pulse: got %b want 1", br_taken_o);
    end
    checks++;
    if (br_target_o !== 16'h0040) begin
      errors++; $display("FAIL taken_target: got %h want 0040", br_target_o);
    end
    checks++;
    if (taken_cnt_o !== 16'd1) begin
      errors++; $display("FAIL taken_cnt: got %0d want 1", taken_cnt_o);
    end
    n = (flush_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (flush_o === 1'b1) n++;
      checks++;
      if (br_taken_o !== 1'b0) begin
        errors++; $display("FAIL taken_single_pulse: got %b want 0", br_taken_o);
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL taken_flush_len: got %0d want 4", n);
    end
    checks++;
    if (br_target_o !== 16'h0040) begin
      errors++; $display("FAIL taken_target_hold: got %h want 0040", br_target_o);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    branchen_i   = 1'b1;
    condcode_i   = 4'd1;
    branchtrgt_i = 16'h0123;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b0) begin
      errors++; $display("FAIL nt_taken: got %b want 0", br_taken_o);
    end
    checks++;
    if (flush_o !== 1'b0) begin
      errors++; $display("FAIL nt_flush: got %b want 0", flush_o);
    end
    checks++;
    if (taken_cnt_o !== 16'd0) begin
      errors++; $display("FAIL nt_cnt: got %0d want 0", taken_cnt_o);
    end
    checks++;
    if (br_target_o !== 16'h0000) begin
      errors++; $display("FAIL nt_target: got %h want 0000", br_target_o);
    end
  endtask

  task automatic test_squash();
    do_reset();
    branchen_i   = 1'b1;
    condcode_i   = 4'd0;
    branchtrgt_i = 16'h0080;
    step();
    checks++;
    if (br_taken_o !== 1'b1) begin
      errors++; $display("FAIL sq_first: got %b want 1", br_taken_o);
    end
    sr_we_i      = 1'b1;
    flags_i      = 4'b1111;
    branchtrgt_i = 16'h00C0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (br_taken_o !== 1'b0) begin
        errors++; $display("FAIL sq_taken[%0d]: got %b want 0", i, br_taken_o);
      end
      checks++;
      if (flush_o !== (i < 3)) begin
        errors++; $display("FAIL sq_flush[%0d]: got %b want %b", i, flush_o, i < 3);
      end
    end
    checks++;
    if (sr_o !== 4'b0000) begin
      errors++; $display("FAIL sq_sr: got %b want 0000", sr_o);
    end
    sr_we_i = 1'b0;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b1) begin
      errors++; $display("FAIL sq_after: got %b want 1", br_taken_o);
    end
    checks++;
    if (br_target_o !== 16'h00C0) begin
      errors++; $display("FAIL sq_target: got %h want 00c0", br_target_o);
    end
    checks++;
    if (taken_cnt_o !== 16'd2) begin
      errors++; $display("FAIL sq_cnt: got %0d want 2", taken_cnt_o);
    end
    repeat (4) step();
  endtask

  task automatic test_cond_sweep();
    logic exp;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 16; c++) begin
        idle_in();
        sr_we_i = 1'b1;
        flags_i = 4'(s);
        step();
        idle_in();
        branchen_i   = 1'b1;
        condcode_i   = 4'(c);
        branchtrgt_i = 16'(s * 16 + c);
        step();
        idle_in();
        exp = model(4'(c), 4'(s));
        checks++;
        if (br_taken_o !== exp) begin
          errors++;
          $display("FAIL sweep cc=%0d sr=%b: got %b want %b", c, s[3:0], br_taken_o, exp);
        end
        if (exp) repeat (4) step();
      end
    end
  endtask

  task automatic test_both();
    do_reset();
    branchen_i   = 1'b1;
    condcode_i   = 4'd1;
    branchtrgt_i = 16'h0010;
    sr_we_i      = 1'b1;
    flags_i      = 4'b0100;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b0) begin
      errors++; $display("FAIL both_pre_sr: got %b want 0", br_taken_o);
    end
    checks++;
    if (sr_o !== 4'b0100) begin
      errors++; $display("FAIL both_sr: got %b want 0100", sr_o);
    end
    branchen_i   = 1'b1;
    condcode_i   = 4'd1;
    branchtrgt_i = 16'h0020;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b1) begin
      errors++; $display("FAIL both_next: got %b want 1", br_taken_o);
    end
    checks++;
    if (br_target_o !== 16'h0020) begin
      errors++; $display("FAIL both_target: got %h want 0020", br_target_o);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    branchen_i   = 1'b1;
    condcode_i   = 4'd0;
    branchtrgt_i = 16'h0100;
    sr_we_i      = 1'b1;
    flags_i      = 4'b1010;
    step();
    idle_in();
    step();
    checks++;
    if (flush_o !== 1'b1 || sr_o !== 4'b1010 || taken_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL mid_pre: got flush=%b sr=%b cnt=%0d want 1 1010 1",
               flush_o, sr_o, taken_cnt_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b0) begin
      errors++; $display("FAIL mid_flush: got %b want 0", flush_o);
    end
    checks++;
    if (br_taken_o !== 1'b0) begin
      errors++; $display("FAIL mid_taken: got %b want 0", br_taken_o);
    end
    checks++;
    if (sr_o !== 4'b0000) begin
      errors++; $display("FAIL mid_sr: got %b want 0000", sr_o);
    end
    checks++;
    if (taken_cnt_o !== 16'd0) begin
      errors++; $display("FAIL mid_cnt: got %0d want 0", taken_cnt_o);
    end
    @(negedge clk);
    rst          = 1'b1;
    branchen_i   = 1'b1;
    condcode_i   = 4'd0;
    branchtrgt_i = 16'h0200;
    step();
    idle_in();
    checks++;
    if (br_taken_o !== 1'b1) begin
      errors++; $display("FAIL mid_after: got %b want 1", br_taken_o);
    end
    checks++;
    if (br_target_o !== 16'h0200) begin
      errors++; $display("FAIL mid_target: got %h want 0200", br_target_o);
    end
    repeat (4) step();
  endtask

  task automatic test_saturate();
    logic [15:0] exp [3];
    exp[0] = 16'hFFFE;
    exp[1] = 16'hFFFF;
    exp[2] = 16'hFFFF;
    do_reset();
    dut.taken_cnt_q = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      branchen_i   = 1'b1;
      condcode_i   = 4'd0;
      branchtrgt_i = 16'h0300;
      step();
      idle_in();
      checks++;
      if (br_taken_o !== 1'b1) begin
        errors++; $display("FAIL sat_taken[%0d]: got %b want 1", i, br_taken_o);
      end
      checks++;
      if (taken_cnt_o !== exp[i]) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, taken_cnt_o, exp[i]);
      end
      repeat (4) step();
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_squash();
    test_cond_sweep();
    test_both();
    test_reset_mid_flush();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 4, number of cycles younger in-flight instructions are squashed after a taken branch; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 branchen_i  input  1  instruction from ex2 is a branch.
REQ-005 condcode_i  input  `cond_code_width (4)  branch condition code.
REQ-006 branchtrgt_i  input  `im_addr_width  branch target address.
REQ-007 sr_we_i  input  1  instruction from ex2 writes the status register.
REQ-008 flags_i  input  4  {N,Z,C,V} produced by the DSP execution unit for the same instruction.
REQ-009 br_taken_o  output  1  one-cycle pulse: redirect fetch.
REQ-010 br_target_o  output  `im_addr_width  redirect address, valid while br_taken_o high.
REQ-011 flush_o  output  1  squash signal to upstream stages.
REQ-012 sr_o  output  4  current status register {N,Z,C,V}.
REQ-013 taken_cnt_o  output  16  saturating count of taken branches.

Function
REQ-014 Inputs are accepted only when state is IDLE; in FLUSH all inputs are ignored (no SR write, no branch evaluation, no count).
REQ-015 Accepted sr_we_i=1 loads sr_o <= flags_i at the clock edge; otherwise sr_o holds.
REQ-016 Condition is evaluated against the registered sr_o, never against flags_i in the same cycle.
REQ-017 Encoding: 0 AL, 1 EQ(Z), 2 NE(!Z), 3 CS(C), 4 CC(!C), 5 MI(N), 6 PL(!N), 7 VS(V), 8 VC(!V), 9 HI(C&!Z), 10 LS(!C|Z), 11 GE(N==V), 12 LT(N!=V), 13 GT(!Z&N==V), 14 LE(Z|N!=V), 15 NV(never).
REQ-018 Accepted branchen_i=1 with condition true: next cycle br_taken_o=1 for exactly one cycle, br_target_o=registered branchtrgt_i, state -> FLUSH; latency one cycle.
REQ-019 Accepted branchen_i=1 with condition false, or branchen_i=0: br_taken_o=0, state stays IDLE.
REQ-020 br_target_o holds its last value when br_taken_o=0.
REQ-021 FSM: IDLE -> FLUSH on taken branch; FLUSH lasts exactly FLUSH_CYCLES cycles (4-bit down-counter loaded with FLUSH_CYCLES, decremented each cycle), then -> IDLE.
REQ-022 flush_o is registered, high exactly during the FLUSH_CYCLES cycles of FLUSH, first asserted in the same cycle as br_taken_o.
REQ-023 An instruction presented in the final FLUSH cycle is squashed; the first accepted instruction is the one presented in the first cycle flush_o=0.
REQ-024 Instruction with both sr_we_i and branchen_i: branch uses pre-write sr_o, SR still updated.
REQ-025 taken_cnt_o increments by 1 per taken branch, saturates at 16'hFFFF, no wrap.

Reset
REQ-026 rst low asynchronously forces: state IDLE, counter 0, br_taken_o 0, br_target_o 0, flush_o 0, sr_o 4'b0000, taken_cnt_o 0.
REQ-027 rst asserted mid-FLUSH aborts the flush immediately; after release, the first rising edge accepts inputs.

Structure
REQ-028 Condition-code encodings and FSM state encodings reside in the shared defines file alongside `cond_code_width and `im_addr_width.
REQ-029 Condition evaluation is a combinational sub-module cond_eval (inputs condcode, sr; output cond_true).

Verification
REQ-030 sr_we_i=1, flags_i=4'b0100; next cycle branchen_i=1, condcode=1 (EQ), target 0x040 -> br_taken_o pulse, br_target_o=0x040, flush_o high 4 cycles, taken_cnt_o=1.
REQ-031 sr_o=4'b0000, branchen_i=1, condcode=1 -> br_taken_o 0, flush_o 0, taken_cnt_o unchanged.
REQ-032 Taken branch followed by branchen_i=1, condcode=0 (AL), sr_we_i=1 on each of the next 4 cycles -> all squashed: single br_taken_o pulse, sr_o unchanged; AL branch presented in cycle 5 is taken.
REQ-033 All 16 condition codes swept against all 16 sr_o values -> br_taken_o matches REQ-017 table.
REQ-034 rst pulled low in 2nd FLUSH cycle -> flush_o, br_taken_o, sr_o, taken_cnt_o drop to 0 without a clock edge; branch accepted on first edge after release.
REQ-035 taken_cnt_o preloaded by 65535 taken branches, then one more -> stays 16'hFFFF.
